alu_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 16-bit ALU datapath (fn codes 000 pass, 001 inc, 010 dec, 011 add, 100 neg, 101 or, 110 not).
- Accepts one register-to-register command at a time over a valid/ready handshake and owns an 8x16 register file.
- Per command: read operands, drive the ALU, capture result and flags, write back.
- Sits between instruction decode and the ALU in the multi-cycle CPU.

---
 rtl/alu_op_sequencer_if.sv | 39 +++
 rtl/alu_op_sequencer.sv | 117 +++++++++++
 tb/tb_alu_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: bundles the command handshake, register-file preload
// port, ALU operand/result bus and retire status of the ALU op sequencer.
//   master : instruction-decode / ALU side (drives cmd_*, load_*, alu_z/carries)
//   slave  : the sequencer (drives cmd_ready, alu_x/y/fn, done/err/flags/rd_data)
interface alu_op_sequencer_if #(parameter int DW = 16);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [2:0]    cmd_ra;
  logic [2:0]    cmd_rb;
  logic [2:0]    cmd_rd;
  logic          load_en;
  logic [2:0]    load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [2:0]    alu_fn;
  logic [DW-1:0] alu_z;
  logic          alu_carry;
  logic          alu_carry_n_1;
  logic          done;
  logic          err;
  logic [3:0]    flags;
  logic [DW-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    output load_en, load_addr, load_data,
    output alu_z, alu_carry, alu_carry_n_1,
    input  cmd_ready, alu_x, alu_y, alu_fn, done, err, flags, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    input  load_en, load_addr, load_data,
    input  alu_z, alu_carry, alu_carry_n_1,
    output cmd_ready, alu_x, alu_y, alu_fn, done, err, flags, rd_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for the 16-bit ALU. Accepts one
// register-to-register command over valid/ready, owns an 8x16 register file,
// and walks IDLE -> READ -> EXEC -> WB per command.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears FSM, outputs and register file
//   bus    alu_op_sequencer_if.slave (command, preload, ALU bus, retire status)
// Optional build macro ALU_SEQ_BACK2BACK_EN: accept a new command while in WB
// (1 command per 3 cycles). Undefined: accept only in IDLE (1 per 4 cycles).
module alu_op_sequencer #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] FN_PARK    = 3'b111;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t                   state;
  logic [NREG-1:0][DW-1:0]  rf;
  logic [2:0]               op, ra, rb, rd;
  logic                     accept;
  logic                     arith;
  logic [3:0]               new_flags;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  // Carry/overflow are only meaningful for inc and add.
  assign arith     = (op == 3'b001) || (op == 3'b011);
  assign new_flags = {(bus.alu_z == '0), bus.alu_z[DW-1],
                      arith & bus.alu_carry,
                      arith & (bus.alu_carry ^ bus.alu_carry_n_1)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.flags     <= '0;
      bus.rd_data   <= '0;
      bus.alu_x     <= '0;
      bus.alu_y     <= '0;
      bus.alu_fn    <= FN_PARK;
      rf            <= '0;
      op            <= '0;
      ra            <= '0;
      rb            <= '0;
      rd            <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A command accept wins over a same-cycle preload.
          if (accept) begin
            op            <= bus.cmd_op;
            ra            <= bus.cmd_ra;
            rb            <= bus.cmd_rb;
            rd            <= bus.cmd_rd;
            bus.cmd_ready <= 1'b0;
            state         <= READ;
          end else if (bus.load_en) begin
            rf[bus.load_addr] <= bus.load_data;
          end
        end
        READ: begin
          bus.alu_x  <= rf[ra];
          bus.alu_y  <= rf[rb];
          // fn leaves the parked code only for EXEC, so the ALU always sees
          // an fn_sel edge and evaluates.
          bus.alu_fn <= op;
          state      <= EXEC;
        end
        EXEC: begin
          // Result capture and register write share this edge, so a command
          // accepted in WB already reads the retiring value in its READ.
          bus.alu_fn <= FN_PARK;
          bus.done   <= 1'b1;
          bus.err    <= (op == OP_ILLEGAL);
          if (op != OP_ILLEGAL) begin
            rf[rd]      <= bus.alu_z;
            bus.flags   <= new_flags;
            bus.rd_data <= bus.alu_z;
          end
`ifdef ALU_SEQ_BACK2BACK_EN
          bus.cmd_ready <= 1'b1;
`endif
          state <= WB;
        end
        WB: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
`ifdef ALU_SEQ_BACK2BACK_EN
          if (accept) begin
            op            <= bus.cmd_op;
            ra            <= bus.cmd_ra;
            rb            <= bus.cmd_rb;
            rd            <= bus.cmd_rd;
            bus.cmd_ready <= 1'b0;
            state         <= READ;
          end else begin
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
`else
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + randomized bench for alu_op_sequencer with
// a behavioural ALU attached and an arithmetic reference model of the
// register file and flags.
module tb_alu_op_sequencer;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  alu_op_sequencer_if #(.DW(16)) bus();

  alu_op_sequencer #(.NREG(8), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry out of bit 15 and out of bit 14.
  logic [16:0] alu_s;
  logic [15:0] alu_lo;
  always_comb begin
    alu_s  = '0;
    alu_lo = '0;
    case (bus.alu_fn)
      3'b000: alu_s = {1'b0, bus.alu_x};
      3'b001: begin
        alu_s  = {1'b0, bus.alu_x} + 17'd1;
        alu_lo = {1'b0, bus.alu_x[14:0]} + 16'd1;
      end
      3'b010: begin
        alu_s  = {1'b0, bus.alu_x} + 17'h0FFFF;
        alu_lo = {1'b0, bus.alu_x[14:0]} + 16'h7FFF;
      end
      3'b011: begin
        alu_s  = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
        alu_lo = {1'b0, bus.alu_x[14:0]} + {1'b0, bus.alu_y[14:0]};
      end
      3'b100: begin
        alu_s  = {1'b0, ~bus.alu_x} + 17'd1;
        alu_lo = {1'b0, ~bus.alu_x[14:0]} + 16'd1;
      end
      3'b101: alu_s = {1'b0, bus.alu_x | bus.alu_y};
      3'b110: alu_s = {1'b0, ~bus.alu_x};
      default: alu_s = '0;
    endcase
    bus.alu_z         = alu_s[15:0];
    bus.alu_carry     = alu_s[16];
    bus.alu_carry_n_1 = alu_lo[15];
  end

  // Reference model state.
  logic [15:0] m_rf [8];
  logic [3:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result and {Z,N,C,V} from the operation's arithmetic meaning.
  function automatic void ref_exec(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                   output logic [15:0] r, output logic [3:0] f);
    int unsigned s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (op)
      3'd0: r = x;
      3'd1: begin s = int'(x) + 1; r = s[15:0]; c = s[16]; v = (x == 16'h7FFF); end
      3'd2: r = x - 16'd1;
      3'd3: begin
        s = int'(x) + int'(y);
        r = s[15:0];
        c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'd4: r = 16'd0 - x;
      3'd5: r = x | y;
      3'd6: r = ~x;
      default: r = '0;
    endcase
    f = {(r == 16'd0), r[15], c, v};
  endfunction

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
    m_rf[a] = d;
  endtask

  // Issue one command from IDLE and check every cycle through retire.
  // with_load keeps a preload strobe up from accept through EXEC; it must be ignored.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input bit with_load);
    logic [15:0] x, y, r;
    logic [3:0]  f;
    int n;
    x = m_rf[ra];
    y = m_rf[rb];
    ref_exec(op, x, y, r, f);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rd    = rd;
    if (with_load) begin
      bus.load_en   = 1'b1;
      bus.load_addr = rd;
      bus.load_data = x ^ 16'h5A5A;
    end
    check("fn_accept", bus.alu_fn, 3'b111);
    @(negedge clk);  // READ
    bus.cmd_valid = 1'b0;
    check("ready_read", bus.cmd_ready, 1'b0);
    check("done_read", bus.done, 1'b0);
    check("fn_read", bus.alu_fn, 3'b111);
    @(negedge clk);  // EXEC
    check("fn_exec", bus.alu_fn, op);
    check("x_exec", bus.alu_x, x);
    check("y_exec", bus.alu_y, y);
    check("done_exec", bus.done, 1'b0);
    @(negedge clk);  // WB
    bus.load_en = 1'b0;
    check("done_wb", bus.done, 1'b1);
    check("err_wb", bus.err, (op == 3'b111));
    check("fn_wb", bus.alu_fn, 3'b111);
    check("x_wb", bus.alu_x, x);
`ifdef ALU_SEQ_BACK2BACK_EN
    check("ready_wb", bus.cmd_ready, 1'b1);
`else
    check("ready_wb", bus.cmd_ready, 1'b0);
`endif
    if (op != 3'b111) begin
      check("rd_data", bus.rd_data, r);
      m_rf[rd] = r;
      m_flags  = f;
    end
    check("flags", bus.flags, m_flags);
    @(negedge clk);  // IDLE
    check("done_idle", bus.done, 1'b0);
    check("err_idle", bus.err, 1'b0);
    check("ready_idle", bus.cmd_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.cmd_ready, 1'b1);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_flags"}, bus.flags, 4'h0);
    check({tag, "_rd_data"}, bus.rd_data, 16'h0);
    check({tag, "_x"}, bus.alu_x, 16'h0);
    check({tag, "_y"}, bus.alu_y, 16'h0);
    check({tag, "_fn"}, bus.alu_fn, 3'b111);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_rd    = '0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flags = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // add overflow into sign bit
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run_cmd(3'b011, 3'd1, 3'd2, 3'd3, 1'b0);
    check("add_flags", bus.flags, 4'b0101);

    // inc wrap in place
    preload(3'd4, 16'hFFFF);
    run_cmd(3'b001, 3'd4, 3'd4, 3'd4, 1'b0);
    check("inc_flags", bus.flags, 4'b1010);

    // or, then not of the result
    preload(3'd5, 16'h00F0);
    preload(3'd6, 16'h0F0F);
    run_cmd(3'b101, 3'd5, 3'd6, 3'd7, 1'b0);
    run_cmd(3'b110, 3'd7, 3'd7, 3'd0, 1'b0);
    check("not_r0", bus.rd_data, 16'hF000);

    // illegal op after a flagged add: no write, flags kept
    run_cmd(3'b011, 3'd1, 3'd2, 3'd3, 1'b0);
    run_cmd(3'b111, 3'd1, 3'd2, 3'd3, 1'b0);
    run_cmd(3'b000, 3'd3, 3'd3, 3'd6, 1'b0);

    // preload strobe alongside accept and during the command is dropped
    run_cmd(3'b000, 3'd5, 3'd5, 3'd5, 1'b1);
    run_cmd(3'b000, 3'd5, 3'd5, 3'd2, 1'b0);

    // reset during EXEC of an add
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b011;
    bus.cmd_ra    = 3'd1;
    bus.cmd_rb    = 3'd2;
    bus.cmd_rd    = 3'd3;
    @(negedge clk);  // READ
    bus.cmd_valid = 1'b0;
    @(negedge clk);  // EXEC
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midreset");
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flags = '0;
    run_cmd(3'b000, 3'd3, 3'd3, 3'd3, 1'b0);
    check("reset_r3", bus.flags, 4'b1000);

`ifdef ALU_SEQ_BACK2BACK_EN
    // dec then add accepted in WB reading the forwarded value
    preload(3'd1, 16'h0001);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b010;
    bus.cmd_ra    = 3'd1;
    bus.cmd_rb    = 3'd1;
    bus.cmd_rd    = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);  // WB of dec
    check("b2b_done1", bus.done, 1'b1);
    check("b2b_rd1", bus.rd_data, 16'h0000);
    check("b2b_ready_wb", bus.cmd_ready, 1'b1);
    m_rf[2] = 16'h0000;
    m_flags = 4'b1000;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b011;
    bus.cmd_ra    = 3'd2;
    bus.cmd_rb    = 3'd2;
    bus.cmd_rd    = 3'd4;
    @(negedge clk);  // READ
    bus.cmd_valid = 1'b0;
    check("b2b_done_gap", bus.done, 1'b0);
    @(negedge clk);  // EXEC
    check("b2b_x", bus.alu_x, 16'h0000);
    @(negedge clk);  // WB of add, 3 cycles after the first retire
    check("b2b_done2", bus.done, 1'b1);
    check("b2b_rd2", bus.rd_data, 16'h0000);
    check("b2b_flags2", bus.flags, 4'b1000);
    m_rf[4] = 16'h0000;
    @(negedge clk);
`endif

    // randomized commands against the model
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 4) == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end
    // corner operands for inc/add overflow and carry
    preload(3'd1, 16'h8000);
    preload(3'd2, 16'h8000);
    run_cmd(3'b011, 3'd1, 3'd2, 3'd3, 1'b0);
    check("add_cv", bus.flags, 4'b1011);
    preload(3'd1, 16'h7FFF);
    run_cmd(3'b001, 3'd1, 3'd1, 3'd1, 1'b0);
    check("inc_v", bus.flags, 4'b0101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
